// File: rtl/mem_bus_pkg.sv
// Shared types and decode helpers for the load/store unit and its APB drive.
// Latency: none (pure types and combinational functions).
// Backpressure: not applicable.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // func3 encodings, instrCode[14:12]; stores reuse the B/H/W codes.
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Byte-lane enables for a store of the given width at the given offset.
  function automatic logic [3:0] strb_decode(input logic [2:0] func3, input logic [1:0] off);
    logic [3:0] s;
    case (func3)
      F3_B:    s = 4'b0001 << off;
      F3_H:    s = 4'b0011 << off;
      F3_W:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Halves need an even address, words need a word-aligned address.
  function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] off);
    logic m;
    case (func3)
      F3_H, F3_HU: m = off[0];
      F3_W:        m = (off != 2'b00);
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

  // Stores only exist as B/H/W; loads have no encodings 3, 6 or 7.
  function automatic logic is_illegal(input logic we, input logic [2:0] func3);
    if (we) return (func3 > 3'd2);
    return (func3 == 3'd3) || (func3 == 3'd6) || (func3 == 3'd7);
  endfunction

  // Replicate the right-justified store data onto every lane it could hit.
  function automatic logic [31:0] lane_replicate(input logic [2:0] func3, input logic [31:0] d);
    logic [31:0] r;
    case (func3)
      F3_B:    r = {4{d[7:0]}};
      F3_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Picks the addressed byte/half out of a read word and sign/zero extends it.
// Latency: combinational.
// Backpressure: not applicable.
module load_formatter
  import mem_bus_pkg::*;
(
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane selected by the full offset.
  always_comb begin
    w_byte = i_word[7:0];
    case (i_off)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  // Extension by access type.
  always_comb begin
    o_data = 32'd0;
    case (i_func3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      F3_W:    o_data = i_word;
      default: o_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store unit issuing one aligned APB word transfer per request.
// Latency: 3 cycles req->done with a zero-wait slave, +1 per wait state; 1 cycle for rejected requests.
// Backpressure: busy stalls the CPU; PREADY low extends ACCESS up to TIMEOUT_CYC cycles, then aborts.
module mem_access_unit
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wData,
  output logic [31:0] rData,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t        r_state;
  logic          r_we;
  logic [2:0]    r_func3;
  logic [1:0]    r_off;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_word;
  logic          r_done;
  logic          r_err;
  logic          r_psel;
  logic          r_penable;
  logic          r_pwrite;
  logic [31:0]   r_paddr;
  logic [31:0]   r_pwdata;
  logic [3:0]    r_pstrb;

  logic          w_bad;

  assign w_bad = is_misaligned(func3, addr[1:0]) || is_illegal(we, func3);

  // Transfer sequencing: request latch, APB phases, timeout and response capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_we      <= 1'b0;
      r_func3   <= 3'd0;
      r_off     <= 2'd0;
      r_cnt     <= '0;
      r_word    <= 32'd0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= 32'd0;
      r_pwdata  <= 32'd0;
      r_pstrb   <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (req && !r_done) begin
            r_we    <= we;
            r_func3 <= func3;
            r_off   <= addr[1:0];
            if (w_bad) begin
              // Rejected before the bus: answer at once with an error.
              r_word  <= 32'd0;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              r_cnt     <= '0;
              r_psel    <= 1'b1;
              r_penable <= 1'b0;
              r_paddr   <= {addr[31:2], 2'b00};
              r_pwrite  <= we;
              r_pstrb   <= we ? strb_decode(func3, addr[1:0]) : 4'd0;
              r_pwdata  <= we ? lane_replicate(func3, wData) : 32'd0;
              r_state   <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= PSLVERR;
            // Stores and failed reads report a zero word.
            r_word    <= (PSLVERR || r_we) ? 32'd0 : PRDATA;
            r_state   <= ST_RESP;
          end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_word    <= 32'd0;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  load_formatter u_fmt (
    .i_func3 (r_func3),
    .i_off   (r_off),
    .i_word  (r_word),
    .o_data  (rData)
  );

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign err     = r_err;
  assign PSEL    = r_psel;
  assign PENABLE = r_penable;
  assign PWRITE  = r_pwrite;
  assign PADDR   = r_paddr;
  assign PWDATA  = r_pwdata;
  assign PSTRB   = r_pstrb;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small programmable APB slave.
// Latency: not applicable.
// Backpressure: slave wait states and hang are set per vector.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wData = 32'd0;
  logic [31:0] rData;
  logic        done, err, busy;
  logic [31:0] PADDR, PWDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave model knobs and counters.
  int          wait_n = 0;
  bit          hang = 1'b0;
  logic [31:0] slv_data = 32'd0;
  logic        slv_err = 1'b0;
  int          acc_cnt = 0;
  int          n_setup = 0;

  // Per-run observations.
  int          o_done_cyc;
  logic [31:0] o_rdata;
  logic        o_err;
  logic [3:0]  o_strb;
  logic [31:0] o_wdata, o_paddr;
  logic        o_pwrite;
  logic [31:0] o_busy;
  int          o_acc;
  int          o_setups;
  bit          o_psel_seen;

  always #5 clk = ~clk;

  assign PREADY  = PSEL && PENABLE && !hang && (acc_cnt >= wait_n);
  assign PRDATA  = slv_data;
  assign PSLVERR = slv_err;

  always @(posedge clk) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else if (!PENABLE)              acc_cnt <= 0;
    if (PSEL && !PENABLE) n_setup <= n_setup + 1;
  end

  mem_access_unit #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .func3(func3),
    .addr(addr), .wData(wData), .rData(rData), .done(done), .err(err),
    .busy(busy), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // One request; req held until done has been seen, then dropped.
  task automatic run(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int s0;
    bit got;
    s0 = n_setup;
    o_done_cyc = -1; o_busy = 32'd0; o_acc = 0; o_psel_seen = 1'b0;
    o_strb = 4'd0; o_wdata = 32'd0; o_paddr = 32'd0; o_pwrite = 1'b0;
    o_rdata = 32'd0; o_err = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; we = w; func3 = f; addr = a; wData = d;
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (busy && k < 32) o_busy[k] = 1'b1;
      if (PSEL) o_psel_seen = 1'b1;
      if (PSEL && !PENABLE) begin
        o_strb = PSTRB; o_wdata = PWDATA; o_paddr = PADDR; o_pwrite = PWRITE;
      end
      if (PSEL && PENABLE) o_acc++;
      if (done) begin
        o_done_cyc = k; o_err = err; o_rdata = rData; got = 1'b1;
      end
      // Inputs move while busy; the unit must keep what it latched.
      if (k == 1) begin
        addr = a ^ 32'h3; wData = ~d;
      end
    end
    if (!got) check_val("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; func3 = 3'd0; addr = 32'd0; wData = 32'd0;
    repeat (4) @(negedge clk);
    o_setups = n_setup - s0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_ctl"}, {26'd0, done, err, busy, PSEL, PENABLE, PWRITE}, 32'd0);
    check_val({tag, "_paddr"}, PADDR, 32'd0);
    check_val({tag, "_pwdata"}, PWDATA, 32'd0);
    check_val({tag, "_pstrb"}, {28'd0, PSTRB}, 32'd0);
    check_val({tag, "_rdata"}, rData, 32'd0);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1; reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // SW, zero-wait
    run(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    check_val("sw_done_cyc", 32'(o_done_cyc), 32'd3);
    check_val("sw_err", {31'd0, o_err}, 32'd0);
    check_val("sw_strb", {28'd0, o_strb}, 32'hF);
    check_val("sw_paddr", o_paddr, 32'h10);
    check_val("sw_pwdata", o_wdata, 32'hDEADBEEF);
    check_val("sw_pwrite", {31'd0, o_pwrite}, 32'd1);
    check_val("sw_busy", o_busy, 32'hE);
    check_val("sw_rdata", o_rdata, 32'd0);
    check_val("sw_one_xfer", 32'(o_setups), 32'd1);

    // SB at top lane
    run(1'b1, 3'd0, 32'h13, 32'h000000A5);
    check_val("sb_strb", {28'd0, o_strb}, 32'h8);
    check_val("sb_pwdata", o_wdata, 32'hA5A5A5A5);
    check_val("sb_paddr", o_paddr, 32'h10);

    // SH upper half
    run(1'b1, 3'd1, 32'h22, 32'h1234BEEF);
    check_val("sh_strb", {28'd0, o_strb}, 32'hC);
    check_val("sh_pwdata", o_wdata, 32'hBEEFBEEF);

    // LB / LBU lane 3
    slv_data = 32'hA5000000;
    run(1'b0, 3'd0, 32'h13, 32'd0);
    check_val("lb_rdata", o_rdata, 32'hFFFFFFA5);
    check_val("lb_strb", {28'd0, o_strb}, 32'd0);
    check_val("lb_pwrite", {31'd0, o_pwrite}, 32'd0);
    check_val("lb_done_cyc", 32'(o_done_cyc), 32'd3);
    run(1'b0, 3'd4, 32'h13, 32'd0);
    check_val("lbu_rdata", o_rdata, 32'h000000A5);

    // LH / LHU with two wait states
    slv_data = 32'h80011234; wait_n = 2;
    run(1'b0, 3'd1, 32'h22, 32'd0);
    check_val("lh_rdata", o_rdata, 32'hFFFF8001);
    check_val("lh_done_cyc", 32'(o_done_cyc), 32'd5);
    check_val("lh_paddr", o_paddr, 32'h20);
    run(1'b0, 3'd5, 32'h22, 32'd0);
    check_val("lhu_rdata", o_rdata, 32'h00008001);
    wait_n = 0;
    run(1'b0, 3'd1, 32'h20, 32'd0);
    check_val("lh_low_rdata", o_rdata, 32'h00001234);

    // LW whole word
    slv_data = 32'h12345678;
    run(1'b0, 3'd2, 32'h4, 32'd0);
    check_val("lw_rdata", o_rdata, 32'h12345678);

    // Rejected before the bus
    run(1'b0, 3'd2, 32'h06, 32'd0);
    check_val("lw_mis_done_cyc", 32'(o_done_cyc), 32'd1);
    check_val("lw_mis_err", {31'd0, o_err}, 32'd1);
    check_val("lw_mis_rdata", o_rdata, 32'd0);
    check_val("lw_mis_psel", {31'd0, o_psel_seen}, 32'd0);
    run(1'b1, 3'd3, 32'h10, 32'h1);
    check_val("st_ill_done_cyc", 32'(o_done_cyc), 32'd1);
    check_val("st_ill_err", {31'd0, o_err}, 32'd1);
    check_val("st_ill_psel", {31'd0, o_psel_seen}, 32'd0);
    run(1'b1, 3'd1, 32'h21, 32'h1);
    check_val("sh_mis_err", {31'd0, o_err}, 32'd1);
    run(1'b0, 3'd6, 32'h0, 32'd0);
    check_val("ld_ill_err", {31'd0, o_err}, 32'd1);

    // Timeout
    hang = 1'b1;
    run(1'b0, 3'd2, 32'h8, 32'd0);
    check_val("to_done_cyc", 32'(o_done_cyc), 32'd18);
    check_val("to_err", {31'd0, o_err}, 32'd1);
    check_val("to_acc_cycles", 32'(o_acc), 32'd16);
    check_val("to_rdata", o_rdata, 32'd0);
    hang = 1'b0;

    // Slave error
    slv_err = 1'b1; slv_data = 32'h0000FFFF;
    run(1'b0, 3'd2, 32'h8, 32'd0);
    check_val("slverr_err", {31'd0, o_err}, 32'd1);
    check_val("slverr_rdata", o_rdata, 32'd0);
    check_val("slverr_done_cyc", 32'(o_done_cyc), 32'd3);
    slv_err = 1'b0;

    // Reset in the middle of ACCESS
    hang = 1'b1;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; func3 = 3'd2; addr = 32'h40; wData = 32'h55;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (PSEL && PENABLE) seen = 1'b1;
    end
    check_val("rst_reached_access", {31'd0, seen}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    req = 1'b0; we = 1'b0; addr = 32'd0; wData = 32'd0; hang = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run(1'b1, 3'd2, 32'h44, 32'hCAFEF00D);
    check_val("post_rst_done_cyc", 32'(o_done_cyc), 32'd3);
    check_val("post_rst_err", {31'd0, o_err}, 32'd0);
    check_val("post_rst_paddr", o_paddr, 32'h44);
    check_val("post_rst_pwdata", o_wdata, 32'hCAFEF00D);
    check_val("post_rst_one_xfer", 32'(o_setups), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
